// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: two-port sequencer in front of the 1024x32 data memory.
// One access at a time (IDLE -> ACCESS -> RESP), round-robin on conflict.
// All memory-side signals are registered so the active-low write enable is
// stable across the memory's negedge write; out-of-range addresses are flagged.
module data_mem_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [31:0]       a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_done,
    output logic              a_err,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [31:0]       b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_done,
    output logic              b_err,
    output logic [DATA_W-1:0] b_rdata,
    output logic [31:0]       mem_address,
    output logic [DATA_W-1:0] mem_dataInput,
    output logic              mem_writeEnable,
    input  logic [DATA_W-1:0] mem_dataOutput,
    output logic              busy
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_RESP   = 2'b10
    } state_e;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    // A word address is valid only if no bit above the implemented range is set.
    function automatic logic addr_in_range(input logic [31:0] addr);
        addr_in_range = ((addr >> ADDR_W) == 32'd0);
    endfunction

    state_e              state_q, state_d;
    logic                last_grant_q, last_grant_d;
    logic                grant_q, grant_d;
    logic                we_q, we_d;
    logic                in_range_q, in_range_d;
    logic                a_done_q, a_done_d, b_done_q, b_done_d;
    logic                a_err_q, a_err_d, b_err_q, b_err_d;
    logic [DATA_W-1:0]   a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
    logic [31:0]         mem_address_q, mem_address_d;
    logic [DATA_W-1:0]   mem_dataInput_q, mem_dataInput_d;
    logic                mem_we_n_q, mem_we_n_d;

    logic                pick_b_s;
    logic                sel_we_s;
    logic [31:0]         sel_addr_s;
    logic [DATA_W-1:0]   sel_wdata_s;
    logic                sel_in_range_s;
    logic [DATA_W-1:0]   rd_val_s;

    // Out-of-range reads return zero instead of aliased memory contents.
    assign rd_val_s = in_range_q ? mem_dataOutput : {DATA_W{1'b0}};

    // Pick the winner among current requests and mux its access fields.
    always_comb begin
        if (a_req && b_req) begin
            pick_b_s = (last_grant_q == PORT_A);
        end else if (b_req) begin
            pick_b_s = 1'b1;
        end else begin
            pick_b_s = 1'b0;
        end
        if (pick_b_s) begin
            sel_we_s    = b_we;
            sel_addr_s  = b_addr;
            sel_wdata_s = b_wdata;
        end else begin
            sel_we_s    = a_we;
            sel_addr_s  = a_addr;
            sel_wdata_s = a_wdata;
        end
        sel_in_range_s = addr_in_range(sel_addr_s);
    end

    // Sequencer next-state: grant in IDLE, complete in ACCESS, pulse in RESP.
    always_comb begin
        state_d         = state_q;
        last_grant_d    = last_grant_q;
        grant_d         = grant_q;
        we_d            = we_q;
        in_range_d      = in_range_q;
        a_done_d        = 1'b0;
        b_done_d        = 1'b0;
        a_err_d         = 1'b0;
        b_err_d         = 1'b0;
        a_rdata_d       = a_rdata_q;
        b_rdata_d       = b_rdata_q;
        mem_address_d   = mem_address_q;
        mem_dataInput_d = mem_dataInput_q;
        mem_we_n_d      = mem_we_n_q;
        case (state_q)
            ST_IDLE: begin
                if (a_req || b_req) begin
                    state_d         = ST_ACCESS;
                    grant_d         = pick_b_s;
                    last_grant_d    = pick_b_s;
                    we_d            = sel_we_s;
                    in_range_d      = sel_in_range_s;
                    mem_address_d   = sel_addr_s;
                    mem_dataInput_d = sel_wdata_s;
                    mem_we_n_d      = ~(sel_we_s & sel_in_range_s);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                state_d    = ST_RESP;
                mem_we_n_d = 1'b1;
                if (grant_q == PORT_B) begin
                    b_done_d = 1'b1;
                    b_err_d  = ~in_range_q;
                    if (!we_q) begin
                        b_rdata_d = rd_val_s;
                    end else begin
                        b_rdata_d = b_rdata_q;
                    end
                end else begin
                    a_done_d = 1'b1;
                    a_err_d  = ~in_range_q;
                    if (!we_q) begin
                        a_rdata_d = rd_val_s;
                    end else begin
                        a_rdata_d = a_rdata_q;
                    end
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d    = ST_IDLE;
                mem_we_n_d = 1'b1;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q         <= ST_IDLE;
            last_grant_q    <= PORT_B;
            grant_q         <= PORT_A;
            we_q            <= 1'b0;
            in_range_q      <= 1'b0;
            a_done_q        <= 1'b0;
            b_done_q        <= 1'b0;
            a_err_q         <= 1'b0;
            b_err_q         <= 1'b0;
            a_rdata_q       <= {DATA_W{1'b0}};
            b_rdata_q       <= {DATA_W{1'b0}};
            mem_address_q   <= 32'd0;
            mem_dataInput_q <= {DATA_W{1'b0}};
            mem_we_n_q      <= 1'b1;
        end else begin
            state_q         <= state_d;
            last_grant_q    <= last_grant_d;
            grant_q         <= grant_d;
            we_q            <= we_d;
            in_range_q      <= in_range_d;
            a_done_q        <= a_done_d;
            b_done_q        <= b_done_d;
            a_err_q         <= a_err_d;
            b_err_q         <= b_err_d;
            a_rdata_q       <= a_rdata_d;
            b_rdata_q       <= b_rdata_d;
            mem_address_q   <= mem_address_d;
            mem_dataInput_q <= mem_dataInput_d;
            mem_we_n_q      <= mem_we_n_d;
        end
    end

    assign a_done          = a_done_q;
    assign a_err           = a_err_q;
    assign a_rdata         = a_rdata_q;
    assign b_done          = b_done_q;
    assign b_err           = b_err_q;
    assign b_rdata         = b_rdata_q;
    assign mem_address     = mem_address_q;
    assign mem_dataInput   = mem_dataInput_q;
    assign mem_writeEnable = mem_we_n_q;
    assign busy            = (state_q != ST_IDLE);

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: directed scenarios plus randomized rounds
// checked against a transaction-level model of arbitration and memory.
module tb_data_mem_arbiter;

    logic        clk;
    logic        reset_n;
    logic        a_req, a_we, b_req, b_we;
    logic [31:0] a_addr, a_wdata, b_addr, b_wdata;
    logic        a_done, a_err, b_done, b_err;
    logic [31:0] a_rdata, b_rdata;
    logic [31:0] mem_address, mem_dataInput, mem_dataOutput;
    logic        mem_writeEnable;
    logic        busy;

    logic [31:0] mem     [0:1023];
    logic [31:0] ref_mem [0:1023];
    int          we_low_cnt;
    int          total_cnt;
    int          pass_cnt;
    logic        model_last_b;
    logic [31:0] exp_a_rdata, exp_b_rdata;

    data_mem_arbiter #(.DATA_W(32), .ADDR_W(10)) dut (
        .clk(clk), .reset_n(reset_n),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_done(a_done), .a_err(a_err), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_done(b_done), .b_err(b_err), .b_rdata(b_rdata),
        .mem_address(mem_address), .mem_dataInput(mem_dataInput),
        .mem_writeEnable(mem_writeEnable), .mem_dataOutput(mem_dataOutput),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory: async read, negedge write, active-low write enable.
    assign mem_dataOutput = mem[mem_address[9:0]];
    always @(negedge clk) begin
        if (mem_writeEnable === 1'b0) begin
            mem[mem_address[9:0]] <= mem_dataInput;
            we_low_cnt <= we_low_cnt + 1;
        end
    end

    function automatic logic [31:0] rand_addr();
        if ($urandom_range(0, 7) == 0) return $urandom | 32'h0000_0400;
        return 32'($urandom_range(0, 15));
    endfunction

    // Single access on one port from IDLE; returns observed latency and results.
    task automatic single_access(input logic pb, input logic we, input logic [31:0] addr,
                                 input logic [31:0] wd, output int lat,
                                 output logic [31:0] rd, output logic er, output int wl);
        int start;
        start = we_low_cnt; lat = 99; rd = 32'd0; er = 1'b0;
        if (pb) begin b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = wd; end
        else    begin a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wd; end
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            if ((pb ? b_done : a_done) === 1'b1) begin
                lat = k; rd = pb ? b_rdata : a_rdata; er = pb ? b_err : a_err;
                break;
            end
        end
        a_req = 1'b0; b_req = 1'b0;
        @(posedge clk); #1;
        wl = we_low_cnt - start;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; a_req = 1'b1; b_req = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            total_cnt++; if (a_done !== 1'b0) $display("FAIL t1_a_done got %0h exp 0", a_done); else pass_cnt++;
            total_cnt++; if (b_done !== 1'b0) $display("FAIL t1_b_done got %0h exp 0", b_done); else pass_cnt++;
            total_cnt++; if (a_err !== 1'b0) $display("FAIL t1_a_err got %0h exp 0", a_err); else pass_cnt++;
            total_cnt++; if (b_err !== 1'b0) $display("FAIL t1_b_err got %0h exp 0", b_err); else pass_cnt++;
            total_cnt++; if (a_rdata !== 32'd0) $display("FAIL t1_a_rdata got %0h exp 0", a_rdata); else pass_cnt++;
            total_cnt++; if (b_rdata !== 32'd0) $display("FAIL t1_b_rdata got %0h exp 0", b_rdata); else pass_cnt++;
            total_cnt++; if (mem_address !== 32'd0) $display("FAIL t1_mem_address got %0h exp 0", mem_address); else pass_cnt++;
            total_cnt++; if (mem_dataInput !== 32'd0) $display("FAIL t1_mem_dataInput got %0h exp 0", mem_dataInput); else pass_cnt++;
            total_cnt++; if (mem_writeEnable !== 1'b1) $display("FAIL t1_mem_we got %0h exp 1", mem_writeEnable); else pass_cnt++;
            total_cnt++; if (busy !== 1'b0) $display("FAIL t1_busy got %0h exp 0", busy); else pass_cnt++;
        end
        a_req = 1'b0; b_req = 1'b0; reset_n = 1'b1;
        model_last_b = 1'b1; exp_a_rdata = 32'd0; exp_b_rdata = 32'd0;
    endtask

    task automatic test_write_read();
        int start, lat, wl;
        logic [31:0] rd;
        logic er;
        start = we_low_cnt;
        a_req = 1'b1; a_we = 1'b1; a_addr = 32'd5; a_wdata = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        total_cnt++; if (busy !== 1'b1) $display("FAIL t2_busy_access got %0h exp 1", busy); else pass_cnt++;
        total_cnt++; if (mem_writeEnable !== 1'b0) $display("FAIL t2_we_access got %0h exp 0", mem_writeEnable); else pass_cnt++;
        total_cnt++; if (mem_address !== 32'd5) $display("FAIL t2_mem_address got %0h exp 5", mem_address); else pass_cnt++;
        total_cnt++; if (mem_dataInput !== 32'hDEAD_BEEF) $display("FAIL t2_mem_dataInput got %0h exp deadbeef", mem_dataInput); else pass_cnt++;
        total_cnt++; if (a_done !== 1'b0) $display("FAIL t2_done_early got %0h exp 0", a_done); else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++; if (a_done !== 1'b1) $display("FAIL t2_a_done got %0h exp 1", a_done); else pass_cnt++;
        total_cnt++; if (a_err !== 1'b0) $display("FAIL t2_a_err got %0h exp 0", a_err); else pass_cnt++;
        total_cnt++; if (mem_writeEnable !== 1'b1) $display("FAIL t2_we_resp got %0h exp 1", mem_writeEnable); else pass_cnt++;
        total_cnt++; if (we_low_cnt - start !== 1) $display("FAIL t2_we_low_cycles got %0d exp 1", we_low_cnt - start); else pass_cnt++;
        a_req = 1'b0;
        @(posedge clk); #1;
        total_cnt++; if (a_done !== 1'b0) $display("FAIL t2_done_pulse got %0h exp 0", a_done); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL t2_busy_idle got %0h exp 0", busy); else pass_cnt++;
        ref_mem[5] = 32'hDEAD_BEEF;
        model_last_b = 1'b0;
        single_access(1'b1, 1'b0, 32'd5, 32'd0, lat, rd, er, wl);
        total_cnt++; if (lat !== 2) $display("FAIL t2_b_latency got %0d exp 2", lat); else pass_cnt++;
        total_cnt++; if (rd !== 32'hDEAD_BEEF) $display("FAIL t2_b_rdata got %0h exp deadbeef", rd); else pass_cnt++;
        total_cnt++; if (er !== 1'b0) $display("FAIL t2_b_err got %0h exp 0", er); else pass_cnt++;
        total_cnt++; if (wl !== 0) $display("FAIL t2_b_read_we got %0d exp 0", wl); else pass_cnt++;
    endtask

    task automatic test_round_robin();
        logic ea, eb;
        a_req = 1'b1; b_req = 1'b1; a_we = 1'b0; b_we = 1'b0;
        a_addr = 32'd5; b_addr = 32'd16;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1; reset_n = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            ea = ((k % 3) == 2) && ((((k - 2) / 3) % 2) == 0);
            eb = ((k % 3) == 2) && ((((k - 2) / 3) % 2) == 1);
            total_cnt++; if (a_done !== ea) $display("FAIL t3_a_done cyc %0d got %0h exp %0h", k, a_done, ea); else pass_cnt++;
            total_cnt++; if (b_done !== eb) $display("FAIL t3_b_done cyc %0d got %0h exp %0h", k, b_done, eb); else pass_cnt++;
            if (ea) begin
                total_cnt++; if (a_rdata !== ref_mem[5]) $display("FAIL t3_a_rdata got %0h exp %0h", a_rdata, ref_mem[5]); else pass_cnt++;
            end
            if (eb) begin
                total_cnt++; if (b_rdata !== ref_mem[16]) $display("FAIL t3_b_rdata got %0h exp %0h", b_rdata, ref_mem[16]); else pass_cnt++;
            end
        end
        a_req = 1'b0; b_req = 1'b0;
        exp_a_rdata = ref_mem[5];
    endtask

    task automatic test_out_of_range();
        int lat, wl;
        logic [31:0] rd;
        logic er;
        single_access(1'b0, 1'b1, 32'h400, 32'h1234_5678, lat, rd, er, wl);
        total_cnt++; if (lat !== 2) $display("FAIL t4_wr_latency got %0d exp 2", lat); else pass_cnt++;
        total_cnt++; if (er !== 1'b1) $display("FAIL t4_wr_err got %0h exp 1", er); else pass_cnt++;
        total_cnt++; if (wl !== 0) $display("FAIL t4_wr_we_low got %0d exp 0", wl); else pass_cnt++;
        total_cnt++; if (rd !== exp_a_rdata) $display("FAIL t4_wr_rdata_held got %0h exp %0h", rd, exp_a_rdata); else pass_cnt++;
        single_access(1'b0, 1'b0, 32'h400, 32'd0, lat, rd, er, wl);
        total_cnt++; if (rd !== 32'd0) $display("FAIL t4_rd_rdata got %0h exp 0", rd); else pass_cnt++;
        total_cnt++; if (er !== 1'b1) $display("FAIL t4_rd_err got %0h exp 1", er); else pass_cnt++;
        single_access(1'b0, 1'b0, 32'd0, 32'd0, lat, rd, er, wl);
        total_cnt++; if (rd !== ref_mem[0]) $display("FAIL t4_addr0 got %0h exp %0h", rd, ref_mem[0]); else pass_cnt++;
        total_cnt++; if (er !== 1'b0) $display("FAIL t4_addr0_err got %0h exp 0", er); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int start, lat, wl;
        logic [31:0] rd;
        logic er;
        start = we_low_cnt;
        b_req = 1'b1; b_we = 1'b1; b_addr = 32'd7; b_wdata = 32'hA5A5_A5A5;
        @(posedge clk); #1;
        reset_n = 1'b0;
        @(posedge clk); #1;
        total_cnt++; if (busy !== 1'b0) $display("FAIL t5_busy got %0h exp 0", busy); else pass_cnt++;
        total_cnt++; if (mem_writeEnable !== 1'b1) $display("FAIL t5_mem_we got %0h exp 1", mem_writeEnable); else pass_cnt++;
        total_cnt++; if (b_done !== 1'b0) $display("FAIL t5_b_done got %0h exp 0", b_done); else pass_cnt++;
        reset_n = 1'b1; b_req = 1'b0;
        @(posedge clk); #1;
        total_cnt++; if (b_done !== 1'b0) $display("FAIL t5_b_done_after got %0h exp 0", b_done); else pass_cnt++;
        total_cnt++; if (we_low_cnt - start !== 1) $display("FAIL t5_we_low got %0d exp 1", we_low_cnt - start); else pass_cnt++;
        ref_mem[7] = 32'hA5A5_A5A5;
        single_access(1'b0, 1'b0, 32'd7, 32'd0, lat, rd, er, wl);
        total_cnt++; if (rd !== 32'hA5A5_A5A5) $display("FAIL t5_read7 got %0h exp a5a5a5a5", rd); else pass_cnt++;
    endtask

    task automatic test_addr_change();
        int pulses, done_k;
        logic [31:0] rd;
        logic er;
        pulses = 0; done_k = 0; rd = 32'd0; er = 1'b0;
        a_req = 1'b1; a_we = 1'b0; a_addr = 32'd3;
        @(posedge clk); #1;
        a_addr = 32'd9; a_req = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk); #1;
            if (a_done === 1'b1) begin
                pulses++; done_k = k; rd = a_rdata; er = a_err;
            end
        end
        total_cnt++; if (pulses !== 1) $display("FAIL t6_pulses got %0d exp 1", pulses); else pass_cnt++;
        total_cnt++; if (done_k !== 1) $display("FAIL t6_done_cycle got %0d exp 1", done_k); else pass_cnt++;
        total_cnt++; if (rd !== ref_mem[3]) $display("FAIL t6_rdata got %0h exp %0h", rd, ref_mem[3]); else pass_cnt++;
        total_cnt++; if (er !== 1'b0) $display("FAIL t6_err got %0h exp 0", er); else pass_cnt++;
    endtask

    task automatic test_random();
        logic ra, rb, first_b, both, pb, in_r, wea, web;
        logic [31:0] ada, adb, wda, wdb, ad, wd;
        logic [31:0] era_d, erb_d;
        logic era, erb;
        int ka, kb, ncyc, exp_w, start;
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        model_last_b = 1'b1; exp_a_rdata = 32'd0; exp_b_rdata = 32'd0;
        for (int r = 0; r < 40; r++) begin
            ra = 1'($urandom_range(0, 1)); rb = 1'($urandom_range(0, 1));
            if (!ra && !rb) ra = 1'b1;
            wea = 1'($urandom_range(0, 1)); web = 1'($urandom_range(0, 1));
            ada = rand_addr(); adb = rand_addr(); wda = $urandom; wdb = $urandom;
            both = ra && rb;
            first_b = both ? !model_last_b : rb;
            ka = 0; kb = 0; exp_w = 0; era = 1'b0; erb = 1'b0;
            for (int g = 0; g < (both ? 2 : 1); g++) begin
                pb = (g == 0) ? first_b : !first_b;
                ad = pb ? adb : ada; wd = pb ? wdb : wda;
                in_r = (ad < 32'd1024);
                if (pb ? web : wea) begin
                    if (in_r) begin ref_mem[ad[9:0]] = wd; exp_w++; end
                end else begin
                    if (pb) exp_b_rdata = in_r ? ref_mem[ad[9:0]] : 32'd0;
                    else    exp_a_rdata = in_r ? ref_mem[ad[9:0]] : 32'd0;
                end
                if (pb) begin kb = 2 + 3 * g; erb = !in_r; end
                else    begin ka = 2 + 3 * g; era = !in_r; end
                model_last_b = pb;
            end
            era_d = exp_a_rdata; erb_d = exp_b_rdata;
            ncyc = both ? 6 : 3;
            start = we_low_cnt;
            a_req = ra; a_we = wea; a_addr = ada; a_wdata = wda;
            b_req = rb; b_we = web; b_addr = adb; b_wdata = wdb;
            for (int k = 1; k <= ncyc; k++) begin
                @(posedge clk); #1;
                total_cnt++; if (a_done !== (k == ka)) $display("FAIL rnd_a_done r%0d c%0d got %0h exp %0h", r, k, a_done, (k == ka)); else pass_cnt++;
                total_cnt++; if (b_done !== (k == kb)) $display("FAIL rnd_b_done r%0d c%0d got %0h exp %0h", r, k, b_done, (k == kb)); else pass_cnt++;
                if (k == ka) begin
                    total_cnt++; if (a_rdata !== era_d) $display("FAIL rnd_a_rdata r%0d got %0h exp %0h", r, a_rdata, era_d); else pass_cnt++;
                    total_cnt++; if (a_err !== era) $display("FAIL rnd_a_err r%0d got %0h exp %0h", r, a_err, era); else pass_cnt++;
                    a_req = 1'b0;
                end
                if (k == kb) begin
                    total_cnt++; if (b_rdata !== erb_d) $display("FAIL rnd_b_rdata r%0d got %0h exp %0h", r, b_rdata, erb_d); else pass_cnt++;
                    total_cnt++; if (b_err !== erb) $display("FAIL rnd_b_err r%0d got %0h exp %0h", r, b_err, erb); else pass_cnt++;
                    b_req = 1'b0;
                end
            end
            total_cnt++; if (busy !== 1'b0) $display("FAIL rnd_busy r%0d got %0h exp 0", r, busy); else pass_cnt++;
            total_cnt++; if (we_low_cnt - start !== exp_w) $display("FAIL rnd_we_low r%0d got %0d exp %0d", r, we_low_cnt - start, exp_w); else pass_cnt++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        total_cnt = 0; pass_cnt = 0; we_low_cnt = 0;
        reset_n = 1'b0;
        a_req = 1'b0; a_we = 1'b0; a_addr = 32'd0; a_wdata = 32'd0;
        b_req = 1'b0; b_we = 1'b0; b_addr = 32'd0; b_wdata = 32'd0;
        for (int i = 0; i < 1024; i++) begin
            mem[i] = $urandom;
            ref_mem[i] = mem[i];
        end
        test_reset();
        test_write_read();
        test_round_robin();
        test_out_of_range();
        test_reset_mid();
        test_addr_change();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
